vending_core_param: RTL

- Parametrised next-generation vending-machine controller core: N product slots, each with a stock count and a unit price.
- Serves customer purchases, owner restock, owner cash retrieval and owner reprice through a start/done transaction handshake.
- Registered per-transaction error code; no silent wrap of stock or cash.
- Sits between the mode/keypad input logic and the 7-segment and error display drivers. It replaces the fixed 8-slot datapath with mode-wired sub-blocks.

---
 rtl/vending_core_param.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/vending_core_param.sv
// Parametrised vending controller core: per-slot stock/price, buy/restock/retrieve/reprice
// transactions through a start/done handshake with a registered error code.
//
// state    | meaning
// S_IDLE   | waiting for start; request fields latched on start
// S_CHECK  | evaluate error code and change into registers
// S_COMMIT | apply stock/price/cash updates when no error
// S_FINISH | load done/err/err_code/change outputs, return to idle
module vending_core_param #(
    parameter int N_TYPES     = 8,
    parameter int TYPE_W      = 3,
    parameter int SUPPLY_W    = 4,
    parameter int PRICE_W     = 4,
    parameter int AMT_W       = 4,
    parameter int MONEY_W     = 7,
    parameter int ACC_W       = 9,
    parameter int HIST_W      = 12,
    parameter int INIT_SUPPLY = 5,
    parameter int INIT_PRICE  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [TYPE_W-1:0]   sel_type,
    input  logic [MONEY_W-1:0]  money,
    input  logic [AMT_W-1:0]    qty,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [2:0]          err_code,
    output logic [MONEY_W-1:0]  change,
    output logic [ACC_W-1:0]    acc,
    output logic [ACC_W-1:0]    retrieved,
    output logic [HIST_W-1:0]   history,
    output logic [SUPPLY_W-1:0] stock,
    output logic [PRICE_W-1:0]  price
);
    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_COMMIT, S_FINISH} state_t;

    localparam logic [1:0] M_BUY = 2'd0, M_RESTOCK = 2'd1, M_RETRIEVE = 2'd2, M_REPRICE = 2'd3;
    localparam int COST_W = PRICE_W + AMT_W;
    localparam int W1     = (ACC_W > COST_W) ? ACC_W : COST_W;
    localparam int CMP_W  = ((W1 > MONEY_W) ? W1 : MONEY_W) + 1;
    localparam int RS_W   = ((SUPPLY_W > AMT_W) ? SUPPLY_W : AMT_W) + 1;
    localparam int HS_W   = ((HIST_W > ACC_W) ? HIST_W : ACC_W) + 1;

    state_t state, state_nx;

    logic [SUPPLY_W-1:0] stock_mem [N_TYPES];
    logic [PRICE_W-1:0]  price_mem [N_TYPES];

    logic [1:0]         mode_q;
    logic [TYPE_W-1:0]  type_q;
    logic [MONEY_W-1:0] money_q;
    logic [AMT_W-1:0]   qty_q;
    logic [2:0]         code_q;
    logic [MONEY_W-1:0] change_q;

    logic                in_range;
    logic [SUPPLY_W-1:0] cur_stock;
    logic [PRICE_W-1:0]  cur_price;
    logic [PRICE_W-1:0]  new_price;
    logic [COST_W-1:0]   cost;
    logic [CMP_W-1:0]    money_w, cost_w, acc_sum;
    logic [RS_W-1:0]     stock_w, qty_w, rs_sum;
    logic [HS_W-1:0]     hist_sum;
    logic [2:0]          code_nx;
    logic [MONEY_W-1:0]  change_nx;

    assign busy  = (state != S_IDLE);
    assign stock = (int'(sel_type) < N_TYPES) ? stock_mem[sel_type] : '0;
    assign price = (int'(sel_type) < N_TYPES) ? price_mem[sel_type] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_CHECK;
            S_CHECK:  state_nx = S_COMMIT;
            S_COMMIT: state_nx = S_FINISH;
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // All checks work on the latched request so later input changes are ignored.
    always_comb begin
        in_range  = (int'(type_q) < N_TYPES);
        cur_stock = in_range ? stock_mem[type_q] : '0;
        cur_price = in_range ? price_mem[type_q] : '0;
        new_price = qty_q[PRICE_W-1:0];
        cost      = {{AMT_W{1'b0}}, cur_price} * {{PRICE_W{1'b0}}, qty_q};
        money_w   = CMP_W'(money_q);
        cost_w    = CMP_W'(cost);
        acc_sum   = CMP_W'(acc) + cost_w;
        stock_w   = RS_W'(cur_stock);
        qty_w     = RS_W'(qty_q);
        rs_sum    = stock_w + qty_w;
        hist_sum  = HS_W'(history) + HS_W'(acc);

        code_nx = 3'd0;
        case (mode_q)
            M_BUY: begin
                if (!in_range)                               code_nx = 3'd1;
                else if (qty_q == '0)                        code_nx = 3'd2;
                else if (stock_w < qty_w)                    code_nx = 3'd3;
                else if (money_w < cost_w)                   code_nx = 3'd4;
                else if (acc_sum > CMP_W'({ACC_W{1'b1}}))    code_nx = 3'd5;
            end
            M_RESTOCK: begin
                if (!in_range)                               code_nx = 3'd1;
                else if (qty_q == '0)                        code_nx = 3'd2;
                else if (rs_sum > RS_W'({SUPPLY_W{1'b1}}))   code_nx = 3'd6;
            end
            M_REPRICE: begin
                if (!in_range)                               code_nx = 3'd1;
                else if (new_price == '0)                    code_nx = 3'd7;
            end
            default: code_nx = 3'd0;
        endcase

        change_nx = '0;
        if (mode_q == M_BUY)
            change_nx = (code_nx == 3'd0) ? MONEY_W'(money_w - cost_w) : money_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_TYPES; i++) begin
                stock_mem[i] <= SUPPLY_W'(INIT_SUPPLY);
                price_mem[i] <= PRICE_W'(INIT_PRICE);
            end
            mode_q    <= '0;
            type_q    <= '0;
            money_q   <= '0;
            qty_q     <= '0;
            code_q    <= '0;
            change_q  <= '0;
            acc       <= '0;
            retrieved <= '0;
            history   <= '0;
            change    <= '0;
            err       <= 1'b0;
            err_code  <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == S_FINISH);
            case (state)
                S_IDLE: if (start) begin
                    mode_q  <= mode;
                    type_q  <= sel_type;
                    money_q <= money;
                    qty_q   <= qty;
                end
                S_CHECK: begin
                    code_q   <= code_nx;
                    change_q <= change_nx;
                end
                S_COMMIT: if (code_q == 3'd0) begin
                    case (mode_q)
                        M_BUY: begin
                            stock_mem[type_q] <= cur_stock - SUPPLY_W'(qty_q);
                            acc               <= ACC_W'(acc_sum);
                        end
                        M_RESTOCK: stock_mem[type_q] <= SUPPLY_W'(rs_sum);
                        M_RETRIEVE: begin
                            retrieved <= acc;
                            acc       <= '0;
                            history   <= (hist_sum > HS_W'({HIST_W{1'b1}})) ? {HIST_W{1'b1}}
                                                                             : HIST_W'(hist_sum);
                        end
                        default: price_mem[type_q] <= new_price;
                    endcase
                end
                S_FINISH: begin
                    err      <= (code_q != 3'd0);
                    err_code <= code_q;
                    change   <= change_q;
                end
                default: ;
            endcase
        end
    end
endmodule
